// File: rtl/led_pattern_pkg.sv
// Mode encoding shared between the push-button mode counter and the LED pattern generator.
package led_pattern_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'd0;
    localparam mode_t MODE_BLINK  = 2'd1;
    localparam mode_t MODE_RUN    = 2'd2;
    localparam mode_t MODE_BREATH = 2'd3;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Pattern tick prescaler: one-cycle tick every TICK_DIV clocks, synchronously restartable via clr.
module tick_gen #(
    parameter int unsigned TICK_DIV = 12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] presc_q;
    logic [CW-1:0] presc_d;

    always_comb begin
        presc_d = presc_q + CW'(1);
        if (clr || (presc_q == LAST)) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = (presc_q == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: OFF / BLINK / RUN / BREATH selected by mode, restarted on every mode change.
// BREATH PWM is built only when LED_PATTERN_BREATH_EN is defined; otherwise mode 3 is steady all-ones.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 12_000_000,
    parameter int unsigned LED_WIDTH = 4,
    parameter int unsigned PWM_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    output logic [LED_WIDTH-1:0] led
);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2");
    end
    if (LED_WIDTH < 2) begin : g_bad_led_width
        $error("LED_WIDTH must be >= 2");
    end
    if (PWM_BITS < 1) begin : g_bad_pwm_bits
        $error("PWM_BITS must be >= 1");
    end

    mode_t                mode_q;
    mode_t                mode_d;
    logic [LED_WIDTH-1:0] led_q;
    logic [LED_WIDTH-1:0] led_d;
    logic                 entry_c;
    logic                 tick_c;

`ifdef LED_PATTERN_BREATH_EN
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic                dir_q;
    logic                dir_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
`endif

    assign entry_c = (mode != mode_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (entry_c),
        .tick  (tick_c)
    );

    // Mode entry takes priority over a coincident tick, which is dropped.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
`ifdef LED_PATTERN_BREATH_EN
        duty_d    = duty_q;
        dir_d     = dir_q;
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
`endif
        if (entry_c) begin
            mode_d = mode;
`ifdef LED_PATTERN_BREATH_EN
            duty_d    = '0;
            dir_d     = 1'b0;
            pwm_cnt_d = '0;
`endif
            case (mode)
                MODE_OFF:    led_d = '0;
                MODE_BLINK:  led_d = '1;
                MODE_RUN:    led_d = LED_WIDTH'(1);
`ifdef LED_PATTERN_BREATH_EN
                MODE_BREATH: led_d = '0;
`else
                MODE_BREATH: led_d = '1;
`endif
                default:     led_d = '0;
            endcase
        end else begin
            case (mode_q)
                MODE_OFF: led_d = '0;
                MODE_BLINK: begin
                    if (tick_c) led_d = ~led_q;
                end
                MODE_RUN: begin
                    if (tick_c) led_d = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
                end
                MODE_BREATH: begin
`ifdef LED_PATTERN_BREATH_EN
                    led_d = {LED_WIDTH{pwm_cnt_q < duty_q}};
                    // Triangle duty: turn around at both ends without repeating the end value.
                    if (tick_c) begin
                        if (!dir_q) begin
                            if (duty_q == DUTY_MAX) begin
                                dir_d  = 1'b1;
                                duty_d = DUTY_MAX - PWM_BITS'(1);
                            end else begin
                                duty_d = duty_q + PWM_BITS'(1);
                            end
                        end else begin
                            if (duty_q == '0) begin
                                dir_d  = 1'b0;
                                duty_d = PWM_BITS'(1);
                            end else begin
                                duty_d = duty_q - PWM_BITS'(1);
                            end
                        end
                    end
`endif
                end
                default: led_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_OFF;
            led_q  <= '0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
        end
    end

`ifdef LED_PATTERN_BREATH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q    <= '0;
            dir_q     <= 1'b0;
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`endif

    assign led = led_q;

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Consumes the 2-bit mode value produced by the push-button mode counter and drives the board LED bank with one of four patterns: off, blink, running light, or breathing PWM. Sits directly downstream of the key/debounce path in the same `clk` domain. Every pattern change restarts cleanly, so each key press gives a deterministic visible response.

## Interface
- `TICK_DIV`, default 12_000_000: clock cycles per pattern tick. Must be ≥ 2.
- `LED_WIDTH`, default 4: number of LEDs. Must be ≥ 2.
- `PWM_BITS`, default 8: breathing PWM resolution in bits.
- `clk` input 1: single system clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mode` input 2: pattern select. Synchronous to `clk` and driven from a register.
- `led` output LED_WIDTH: LED drive, registered, active-high.

## Operation
- **Mode encoding:** 0 OFF, 1 BLINK, 2 RUN, 3 BREATH.
- **Internal registers:** `mode_q` (2b), prescaler `presc` ($clog2(TICK_DIV) bits), `tick` pulse, `step` state, `duty` (PWM_BITS), `dir` (0 = up), `pwm_cnt` (PWM_BITS, free-running, wraps).
- **tick:**
  - High for one cycle when `presc == TICK_DIV-1`.
  - `presc` then wraps to 0.
- **Mode entry:** occurs when `mode != mode_q`. On that edge:
  - `mode_q <= mode`.
  - `presc`, `pwm_cnt`, `duty` and `dir` clear to 0.
  - `led` loads the entry value: OFF = 0, BLINK = all-ones, RUN = 1 (LSB only), BREATH = 0.
- **Mode entry beats tick:** if entry and tick coincide, entry wins and the tick is discarded.
- **OFF:** `led` = 0 constantly.
- **BLINK:** each tick inverts all `led` bits.
- **RUN:**
  - Each tick rotates `led` left by 1.
  - MSB wraps to LSB.
  - Exactly one bit is set at all times.
- **BREATH:**
  - Each tick updates the triangle duty:
    - Up: `duty == 2^PWM_BITS-1` → `dir <= 1`, `duty <= max-1`; otherwise `duty+1`.
    - Down: `duty == 0` → `dir <= 0`, `duty <= 1`; otherwise `duty-1`.
  - Every cycle `led <= {LED_WIDTH{pwm_cnt < duty}}`.
  - Duty 0 gives always off; max gives on for (2^B−1)/2^B of the time.
- **Reset:** clears all registers including `mode_q` (= 0) and `led` (= 0).
  - If `mode` ≠ 0 when reset releases, entry happens on the first clock edge after release.

## Timing
- `led` reset value is 0.
- Mode change is visible on `led` 1 cycle after `mode` changes (entry value).
- The first tick after entry occurs TICK_DIV cycles after the entry edge. Later ticks follow every TICK_DIV cycles.
- A pattern step appears on `led` on the edge following the tick cycle.
- BREATH has a 1-cycle compare→`led` pipeline. `pwm_cnt` is 0 on the first cycle after entry.
- Reset asserted mid-pattern forces `led` = 0 immediately (asynchronously). Operation restarts on release.

## Configuration
- Macro `LED_PATTERN_BREATH_EN`.
- **Defined:** mode 3 is BREATH as specified above.
- **Undefined:**
  - Mode 3 drives `led` = all-ones steadily, loaded at entry.
  - No `duty`, `dir` or `pwm_cnt` logic is synthesized.

## Structure
- **Shared package `led_pattern_pkg`:** mode constants `MODE_OFF`, `MODE_BLINK`, `MODE_RUN`, `MODE_BREATH`, and a 2-bit mode typedef. Shared with the key/mode counter side.
- **Sub-module `tick_gen`:** parameter TICK_DIV; ports `clk`, `rst_n`, `clr`, `tick`. `clr` is a synchronous clear to 0, driven by mode entry.
- Pattern state and BREATH PWM stay in the top module.

## Test plan
All scenarios use TICK_DIV=4, LED_WIDTH=4, PWM_BITS=3.
- **Reset:** hold `rst_n`=0 with `mode`=2 → `led`=0000. On release → `led`=0001 after 1 edge.
- **RUN:** `mode` 0→2 → 0001, then 0010, 0100, 1000, 0001, each 4 cycles apart (wrap checked).
- **BLINK:** `mode`=1 → 1111 for 4 cycles, then 0000, then 1111 (period 8 cycles).
- **BREATH:**
  - Duty per tick follows 0,1,…,7,6,…,0,1.
  - At duty=3, `led` is high for exactly 3 of every 8 cycles.
  - At duty=0 it is never high.
- **Entry coincides with tick:** switch `mode` 2→1 on the cycle where `presc`=3 → `led`=1111 next cycle. The next toggle comes 4 cycles later, with no extra step.
- **Macro undefined:** `mode`=3 → `led`=1111 steady for ≥ 40 cycles. Assert `rst_n` mid-run → `led`=0000 immediately.
